// File: rtl/l0_derandomizer.sv
// Derandomizing L0 event buffer: captures three-word pipeline events, tags each with a
// local L0ID, queues up to 2**DEPTH_LOG2 events and drains them word-by-word over valid/ready.
module l0_derandomizer #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH_LOG2 = 3,
    parameter int L0ID_WIDTH = 8
) (
    input  logic                  BC,
    input  logic                  SoftReset,
    input  logic [2:0]            L1B_W,
    input  logic [DATA_WIDTH-1:0] PipeData,
    input  logic                  L0IDReset,
    input  logic                  L0IDPreset,
    input  logic [L0ID_WIDTH-1:0] PreL0ID,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic [1:0]            RdWordIdx,
    output logic [L0ID_WIDTH-1:0] RdL0ID,
    output logic                  RdValid,
    input  logic                  RdReady,
    output logic [DEPTH_LOG2:0]   Occupancy,
    output logic                  Overflow,
    output logic                  ProtoErr,
    output logic [7:0]            DropCount
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int OW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_W1   = 2'd1,
        CAP_W2   = 2'd2,
        CAP_DROP = 2'd3
    } capState_t;

    // True when more than one word-phase strobe is asserted in the same cycle.
    function automatic logic multiHot(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    capState_t capState_r;
    capState_t capNext_s;
    capState_t startNext_s;

    logic                  startEvent_s;
    logic                  wr0_s;
    logic                  wr1_s;
    logic                  commit_s;
    logic                  drop_s;
    logic                  protoSet_s;
    logic                  fifoFull_s;

    logic [L0ID_WIDTH-1:0] l0id_r;
    logic [L0ID_WIDTH-1:0] l0idNext_s;

    logic [DEPTH_LOG2-1:0] wrPtr_r;
    logic [DEPTH_LOG2-1:0] rdPtr_r;
    logic [DEPTH_LOG2-1:0] rdPtrNext_s;
    logic [OW-1:0]         occ_r;
    logic [OW-1:0]         occNext_s;
    logic [1:0]            rdIdx_r;
    logic [1:0]            rdIdxNext_s;
    logic                  rdValid_r;
    logic                  rdAccept_s;
    logic                  rdFree_s;
    logic [DATA_WIDTH-1:0] rdWord_s;

    logic [DATA_WIDTH-1:0] rdData_r;
    logic [L0ID_WIDTH-1:0] rdL0id_r;
    logic                  overflow_r;
    logic                  protoErr_r;
    logic [7:0]            dropCount_r;

    logic [DATA_WIDTH-1:0] word0Mem [DEPTH];
    logic [DATA_WIDTH-1:0] word1Mem [DEPTH];
    logic [DATA_WIDTH-1:0] word2Mem [DEPTH];
    logic [L0ID_WIDTH-1:0] l0idMem  [DEPTH];

    assign fifoFull_s  = (occ_r == OW'(DEPTH));
    assign startNext_s = fifoFull_s ? CAP_DROP : CAP_W1;
    assign wr0_s       = startEvent_s & ~fifoFull_s;
    assign drop_s      = startEvent_s & fifoFull_s;

    // Capture state register.
    always_ff @(posedge BC) begin
        if (SoftReset) begin
            capState_r <= CAP_IDLE;
        end else begin
            capState_r <= capNext_s;
        end
    end

    // Capture next-state and write strobes; a 001 out of sequence restarts as a new event.
    always_comb begin
        capNext_s    = capState_r;
        startEvent_s = 1'b0;
        wr1_s        = 1'b0;
        commit_s     = 1'b0;
        protoSet_s   = 1'b0;
        if (multiHot(L1B_W)) begin
            protoSet_s = 1'b1;
            capNext_s  = CAP_IDLE;
        end else begin
            case (capState_r)
                CAP_IDLE: begin
                    case (L1B_W)
                        3'b001: begin
                            startEvent_s = 1'b1;
                            capNext_s    = startNext_s;
                        end
                        3'b010, 3'b100: protoSet_s = 1'b1;
                        default: capNext_s = CAP_IDLE;
                    endcase
                end
                CAP_W1: begin
                    case (L1B_W)
                        3'b010: begin
                            wr1_s     = 1'b1;
                            capNext_s = CAP_W2;
                        end
                        3'b001: begin
                            protoSet_s   = 1'b1;
                            startEvent_s = 1'b1;
                            capNext_s    = startNext_s;
                        end
                        3'b100: begin
                            protoSet_s = 1'b1;
                            capNext_s  = CAP_IDLE;
                        end
                        default: capNext_s = CAP_W1;
                    endcase
                end
                CAP_W2: begin
                    case (L1B_W)
                        3'b100: begin
                            commit_s  = 1'b1;
                            capNext_s = CAP_IDLE;
                        end
                        3'b001: begin
                            protoSet_s   = 1'b1;
                            startEvent_s = 1'b1;
                            capNext_s    = startNext_s;
                        end
                        3'b010: begin
                            protoSet_s = 1'b1;
                            capNext_s  = CAP_IDLE;
                        end
                        default: capNext_s = CAP_W2;
                    endcase
                end
                CAP_DROP: begin
                    case (L1B_W)
                        3'b100: capNext_s = CAP_IDLE;
                        3'b001: begin
                            protoSet_s   = 1'b1;
                            startEvent_s = 1'b1;
                            capNext_s    = startNext_s;
                        end
                        default: capNext_s = CAP_DROP;
                    endcase
                end
                default: capNext_s = CAP_IDLE;
            endcase
        end
    end

    // L0ID next value: reset/preset takes priority over the bit-0 increment.
    always_comb begin
        if (L0IDReset) begin
            l0idNext_s = L0IDPreset ? PreL0ID : {L0ID_WIDTH{1'b1}};
        end else if (L1B_W[0]) begin
            l0idNext_s = l0id_r + L0ID_WIDTH'(1);
        end else begin
            l0idNext_s = l0id_r;
        end
    end

    // L0ID counter register.
    always_ff @(posedge BC) begin
        if (SoftReset) begin
            l0id_r <= {L0ID_WIDTH{1'b1}};
        end else begin
            l0id_r <= l0idNext_s;
        end
    end

    // Event storage; only the uncommitted slot at wrPtr is ever written.
    always_ff @(posedge BC) begin
        if (wr0_s) begin
            word0Mem[wrPtr_r] <= PipeData;
            l0idMem[wrPtr_r]  <= l0idNext_s;
        end
        if (wr1_s) begin
            word1Mem[wrPtr_r] <= PipeData;
        end
        if (commit_s) begin
            word2Mem[wrPtr_r] <= PipeData;
        end
    end

    assign rdAccept_s = rdValid_r & RdReady;
    assign rdFree_s   = rdAccept_s & (rdIdx_r == 2'd2);

    // Read-side next pointers, occupancy and the word to present after this edge.
    always_comb begin
        if (!rdAccept_s) begin
            rdIdxNext_s = rdIdx_r;
        end else if (rdFree_s) begin
            rdIdxNext_s = 2'd0;
        end else begin
            rdIdxNext_s = rdIdx_r + 2'd1;
        end
        rdPtrNext_s = rdFree_s ? (rdPtr_r + DEPTH_LOG2'(1)) : rdPtr_r;
        case ({commit_s, rdFree_s})
            2'b10:   occNext_s = occ_r + OW'(1);
            2'b01:   occNext_s = occ_r - OW'(1);
            default: occNext_s = occ_r;
        endcase
        case (rdIdxNext_s)
            2'd0:    rdWord_s = word0Mem[rdPtrNext_s];
            2'd1:    rdWord_s = word1Mem[rdPtrNext_s];
            2'd2:    rdWord_s = word2Mem[rdPtrNext_s];
            default: rdWord_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Pointers, occupancy and registered read outputs (held when nothing is queued).
    always_ff @(posedge BC) begin
        if (SoftReset) begin
            wrPtr_r   <= {DEPTH_LOG2{1'b0}};
            rdPtr_r   <= {DEPTH_LOG2{1'b0}};
            occ_r     <= {OW{1'b0}};
            rdIdx_r   <= 2'd0;
            rdValid_r <= 1'b0;
            rdData_r  <= {DATA_WIDTH{1'b0}};
            rdL0id_r  <= {L0ID_WIDTH{1'b0}};
        end else begin
            if (commit_s) begin
                wrPtr_r <= wrPtr_r + DEPTH_LOG2'(1);
            end
            rdPtr_r   <= rdPtrNext_s;
            occ_r     <= occNext_s;
            rdIdx_r   <= rdIdxNext_s;
            rdValid_r <= (occNext_s != {OW{1'b0}});
            if (occNext_s != {OW{1'b0}}) begin
                rdData_r <= rdWord_s;
                rdL0id_r <= l0idMem[rdPtrNext_s];
            end
        end
    end

    // Sticky error flags and saturating drop counter.
    always_ff @(posedge BC) begin
        if (SoftReset) begin
            overflow_r  <= 1'b0;
            protoErr_r  <= 1'b0;
            dropCount_r <= 8'd0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (dropCount_r != 8'hFF) begin
                    dropCount_r <= dropCount_r + 8'd1;
                end
            end
            if (protoSet_s) begin
                protoErr_r <= 1'b1;
            end
        end
    end

    assign RdData    = rdData_r;
    assign RdWordIdx = rdIdx_r;
    assign RdL0ID    = rdL0id_r;
    assign RdValid   = rdValid_r;
    assign Occupancy = occ_r;
    assign Overflow  = overflow_r;
    assign ProtoErr  = protoErr_r;
    assign DropCount = dropCount_r;

endmodule

// File: tb/tb_l0_derandomizer.sv
// Self-checking bench for l0_derandomizer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based event model.
module tb_l0_derandomizer;

    localparam int DW    = 256;
    localparam int DL    = 3;
    localparam int IW    = 8;
    localparam int DEPTH = 8;

    logic          BC = 1'b0;
    logic          SoftReset;
    logic [2:0]    L1B_W;
    logic [DW-1:0] PipeData;
    logic          L0IDReset;
    logic          L0IDPreset;
    logic [IW-1:0] PreL0ID;
    logic [DW-1:0] RdData;
    logic [1:0]    RdWordIdx;
    logic [IW-1:0] RdL0ID;
    logic          RdValid;
    logic          RdReady;
    logic [DL:0]   Occupancy;
    logic          Overflow;
    logic          ProtoErr;
    logic [7:0]    DropCount;

    l0_derandomizer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .L0ID_WIDTH(IW)) dut (
        .BC(BC), .SoftReset(SoftReset), .L1B_W(L1B_W), .PipeData(PipeData),
        .L0IDReset(L0IDReset), .L0IDPreset(L0IDPreset), .PreL0ID(PreL0ID),
        .RdData(RdData), .RdWordIdx(RdWordIdx), .RdL0ID(RdL0ID), .RdValid(RdValid),
        .RdReady(RdReady), .Occupancy(Occupancy), .Overflow(Overflow),
        .ProtoErr(ProtoErr), .DropCount(DropCount)
    );

    always #5 BC = ~BC;

    typedef struct packed {
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
        logic [IW-1:0] id;
    } event_t;

    event_t mq[$];
    event_t mPend;
    int     mIdx;
    int     mCap;      // 0 idle, 1 awaiting word 1, 2 awaiting word 2, 3 dropping
    int     mL0id;
    bit     mOvf;
    bit     mProto;
    int     mDrop;
    bit     randReady;

    int nChecks = 0;
    int nFail   = 0;

    task automatic checkEq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] randWord();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Apply the rules for one rising edge to the model, using the inputs present at that edge.
    task automatic modelEdge();
        int  occBefore;
        bit  commit;
        int  nbits;
        if (SoftReset) begin
            mq.delete();
            mIdx = 0; mCap = 0; mL0id = 255; mOvf = 0; mProto = 0; mDrop = 0;
            return;
        end
        occBefore = mq.size();
        commit = 0;
        if (L0IDReset) mL0id = L0IDPreset ? int'(PreL0ID) : 255;
        else if (L1B_W[0]) mL0id = (mL0id + 1) % 256;
        nbits = $countones(L1B_W);
        if (nbits > 1) begin
            mProto = 1; mCap = 0;
        end else if (L1B_W == 3'b001) begin
            if (mCap != 0) mProto = 1;
            if (occBefore == DEPTH) begin
                mOvf = 1;
                if (mDrop < 255) mDrop++;
                mCap = 3;
            end else begin
                mPend.id = IW'(mL0id);
                mPend.w0 = PipeData;
                mCap = 1;
            end
        end else if (L1B_W == 3'b010) begin
            if (mCap == 1) begin
                mPend.w1 = PipeData; mCap = 2;
            end else if (mCap != 3) begin
                mProto = 1; mCap = 0;
            end
        end else if (L1B_W == 3'b100) begin
            if (mCap == 2) begin
                mPend.w2 = PipeData; commit = 1; mCap = 0;
            end else if (mCap == 3) begin
                mCap = 0;
            end else begin
                mProto = 1; mCap = 0;
            end
        end
        if (occBefore > 0 && RdReady) begin
            if (mIdx == 2) begin
                void'(mq.pop_front());
                mIdx = 0;
            end else begin
                mIdx++;
            end
        end
        if (commit) mq.push_back(mPend);
    endtask

    task automatic checkOutputs();
        logic [DW-1:0] expWord;
        checkEq("RdValid", RdValid, mq.size() > 0);
        checkEq("Occupancy", Occupancy, mq.size());
        checkEq("Overflow", Overflow, mOvf);
        checkEq("ProtoErr", ProtoErr, mProto);
        checkEq("DropCount", DropCount, mDrop);
        if (mq.size() > 0) begin
            expWord = (mIdx == 0) ? mq[0].w0 : (mIdx == 1) ? mq[0].w1 : mq[0].w2;
            checkEq("RdWordIdx", RdWordIdx, mIdx);
            checkEq("RdL0ID", RdL0ID, mq[0].id);
            checkEq("RdData", RdData, expWord);
        end
    endtask

    task automatic cycle();
        if (randReady) RdReady = ($urandom_range(0, 3) != 0);
        @(posedge BC);
        modelEdge();
        #1;
        checkOutputs();
    endtask

    task automatic drive(input logic [2:0] l1b, input logic [DW-1:0] d);
        L1B_W    = l1b;
        PipeData = d;
        cycle();
        L1B_W    = 3'b000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(3'b000, randWord());
    endtask

    task automatic sendEvent(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        drive(3'b001, a);
        drive(3'b010, b);
        drive(3'b100, c);
    endtask

    task automatic doReset();
        SoftReset = 1'b1;
        drive(3'b000, randWord());
        SoftReset = 1'b0;
        checkEq("rst RdData", RdData, '0);
        checkEq("rst RdWordIdx", RdWordIdx, 2'd0);
        checkEq("rst RdL0ID", RdL0ID, 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        int r;
        SoftReset = 1'b1; L1B_W = 3'b000; PipeData = '0; L0IDReset = 1'b0;
        L0IDPreset = 1'b0; PreL0ID = 8'd0; RdReady = 1'b0; randReady = 0;
        mIdx = 0; mCap = 0; mL0id = 255; mOvf = 0; mProto = 0; mDrop = 0;
        @(posedge BC);
        doReset();

        // Single event, consumer always ready; first L0ID is 0.
        RdReady = 1'b1;
        a = randWord(); b = randWord(); c = randWord();
        sendEvent(a, b, c);
        checkEq("t1 RdValid after commit", RdValid, 1'b1);
        checkEq("t1 first L0ID", RdL0ID, 8'd0);
        checkEq("t1 word0", RdData, a);
        idle(5);
        checkEq("t1 empty", Occupancy, 4'd0);

        // Fill with consumer stalled, ninth event dropped, then drain.
        doReset();
        RdReady = 1'b0;
        for (int i = 0; i < 9; i++) sendEvent(randWord(), randWord(), randWord());
        checkEq("t2 full", Occupancy, 4'd8);
        checkEq("t2 overflow", Overflow, 1'b1);
        checkEq("t2 dropcount", DropCount, 8'd1);
        RdReady = 1'b1;
        idle(26);
        sendEvent(randWord(), randWord(), randWord());
        checkEq("t2 next L0ID", RdL0ID, 8'd9);
        idle(4);

        // Drop counter saturation.
        RdReady = 1'b0;
        for (int i = 0; i < 8; i++) sendEvent(randWord(), randWord(), randWord());
        for (int i = 0; i < 260; i++) sendEvent(randWord(), randWord(), randWord());
        checkEq("t2 dropcount sat", DropCount, 8'hFF);
        doReset();

        // Back-to-back events with continuous draining: commit meets free.
        RdReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sendEvent(randWord(), randWord(), randWord());
            if (i > 0) checkEq("t3 occ steady", Occupancy, 4'd1);
        end
        idle(4);

        // Multi-hot strobe mid-event abandons the partial event.
        doReset();
        drive(3'b001, randWord());
        drive(3'b011, randWord());
        checkEq("t4 protoerr", ProtoErr, 1'b1);
        checkEq("t4 occ", Occupancy, 4'd0);
        idle(2);
        checkEq("t4 no output", RdValid, 1'b0);
        sendEvent(randWord(), randWord(), randWord());
        idle(4);

        // L0ID preset, then soft reset in the middle of a drain.
        doReset();
        L0IDReset = 1'b1; L0IDPreset = 1'b1; PreL0ID = 8'h41;
        drive(3'b000, randWord());
        L0IDReset = 1'b0; L0IDPreset = 1'b0;
        RdReady = 1'b0;
        sendEvent(randWord(), randWord(), randWord());
        checkEq("t5 preset L0ID", RdL0ID, 8'h42);
        RdReady = 1'b1;
        idle(1);
        doReset();
        checkEq("t5 rst valid", RdValid, 1'b0);
        checkEq("t5 rst occ", Occupancy, 4'd0);
        idle(3);

        // Randomized traffic.
        randReady = 1;
        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                drive(3'b001, randWord());
                if ($urandom_range(0, 4) == 0) idle(1);
                drive(3'b010, randWord());
                if ($urandom_range(0, 4) == 0) idle(1);
                drive(3'b100, randWord());
            end else if (r < 75) begin
                idle($urandom_range(1, 4));
            end else if (r < 85) begin
                a = randWord();
                drive(3'b001 << $urandom_range(0, 2), a);
            end else if (r < 92) begin
                a = randWord();
                drive(($urandom_range(0, 3) == 0) ? 3'b111 : (3'b011 << $urandom_range(0, 1)), a);
            end else if (r < 99) begin
                L0IDReset  = 1'b1;
                L0IDPreset = $urandom_range(0, 1);
                PreL0ID    = 8'($urandom);
                drive(3'b000, randWord());
                L0IDReset  = 1'b0;
            end else begin
                doReset();
            end
        end
        randReady = 0;
        RdReady = 1'b1;
        idle(30);
        checkEq("final drained", Occupancy, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
